// File: rtl/fetch_unit_pkg.sv
// Shared encodings between the fetch unit and the control unit:
// stack-pointer operation select and RAM address source select.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    SP_HOLD   = 2'b00,
    SP_PUSH   = 2'b01,
    SP_POP    = 2'b10,
    SP_RELOAD = 2'b11
  } sp_op_e;

  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_MAR = 1'b1;

endpackage

// File: rtl/fetch_unit_stack_pointer.sv
// Stack pointer: pre-decrement push, post-increment pop, reload to top of RAM,
// and a sticky overflow/underflow flag that only reset clears.
module fetch_unit_stack_pointer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_sp_sel,
  output logic [ADDR_W-1:0] o_sp_val,
  output logic [ADDR_W-1:0] o_sp_addr,
  output logic              o_sp_active,
  output logic              o_stack_err
);

  logic [ADDR_W-1:0] r_sp;
  logic              r_stack_err;
  logic [ADDR_W-1:0] w_sp_dec;
  logic [ADDR_W-1:0] w_sp_inc;
  logic              w_overflow;
  logic              w_underflow;

  assign w_sp_dec    = r_sp - 1'b1;
  assign w_sp_inc    = r_sp + 1'b1;
  assign w_overflow  = (i_sp_sel == SP_PUSH) && (r_sp == '0);
  assign w_underflow = (i_sp_sel == SP_POP)  && (r_sp == SP_RESET);

  // Push addresses the slot below SP; pop and reload address SP itself.
  assign o_sp_addr   = (i_sp_sel == SP_PUSH) ? w_sp_dec : r_sp;
  assign o_sp_active = (i_sp_sel != SP_HOLD);
  assign o_sp_val    = r_sp;
  assign o_stack_err = r_stack_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sp        <= SP_RESET;
      r_stack_err <= 1'b0;
    end else begin
      case (i_sp_sel)
        SP_PUSH:   r_sp <= w_sp_dec;
        SP_POP:    r_sp <= w_sp_inc;
        SP_RELOAD: r_sp <= SP_RESET;
        default:   r_sp <= r_sp;
      endcase
      if (w_overflow || w_underflow) r_stack_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC, MAR, IR and the RAM address mux; the stack pointer lives in
// its own sub-module and takes over the RAM address whenever a stack op is active.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       bus_in,
  input  logic              pc_enable,
  input  logic              pcin,
  input  logic              pcout,
  input  logic              addr_in,
  input  logic              instr_enable,
  input  logic              ram_addr_sel,
  input  logic [1:0]        sp_sel,
  input  logic [15:0]       ram_rdata,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       bus_out,
  output logic              bus_oe,
  output logic [ADDR_W-1:0] sp_val,
  output logic              stack_err
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [15:0]       r_ir;
  logic [ADDR_W-1:0] w_sp_addr;
  logic              w_sp_active;
  logic [15:0]       w_pc_ext;

  fetch_unit_stack_pointer #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_stack_pointer (
    .clk         (clk),
    .rst         (rst),
    .i_sp_sel    (sp_sel),
    .o_sp_val    (sp_val),
    .o_sp_addr   (w_sp_addr),
    .o_sp_active (w_sp_active),
    .o_stack_err (stack_err)
  );

  // pcin wins over pc_enable: a jump never also increments.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc  <= PC_RESET;
      r_mar <= '0;
      r_ir  <= '0;
    end else begin
      if (pcin)           r_pc <= bus_in[ADDR_W-1:0];
      else if (pc_enable) r_pc <= r_pc + 1'b1;
      if (addr_in)        r_mar <= bus_in[ADDR_W-1:0];
      if (instr_enable)   r_ir  <= ram_rdata;
    end
  end

  always_comb begin
    w_pc_ext             = '0;
    w_pc_ext[ADDR_W-1:0] = r_pc;
  end

  always_comb begin
    ram_addr = r_pc;
    if (w_sp_active)                        ram_addr = w_sp_addr;
    else if (ram_addr_sel == ADDR_SEL_MAR)  ram_addr = r_mar;
  end

  assign instr   = r_ir;
  assign bus_out = w_pc_ext;
  assign bus_oe  = pcout;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency RAM model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] bus_in;
  logic        pc_enable;
  logic        pcin;
  logic        pcout;
  logic        addr_in;
  logic        instr_enable;
  logic        ram_addr_sel;
  logic [1:0]  sp_sel;
  logic [15:0] ram_rdata;
  logic [15:0] instr;
  logic [15:0] ram_addr;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic [15:0] sp_val;
  logic        stack_err;

  logic [15:0] mem [0:65535];
  int n_assert;
  int n_fail;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .bus_in       (bus_in),
    .pc_enable    (pc_enable),
    .pcin         (pcin),
    .pcout        (pcout),
    .addr_in      (addr_in),
    .instr_enable (instr_enable),
    .ram_addr_sel (ram_addr_sel),
    .sp_sel       (sp_sel),
    .ram_rdata    (ram_rdata),
    .instr        (instr),
    .ram_addr     (ram_addr),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .sp_val       (sp_val),
    .stack_err    (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= mem[ram_addr];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_in = '0; pc_enable = 0; pcin = 0; pcout = 0; addr_in = 0;
    instr_enable = 0; ram_addr_sel = 0; sp_sel = 2'b00;
  endtask

  // Advance one edge, then let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    ram_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i ^ 16'h5a5a);
    mem[0] = 16'h1234;
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_ram_addr", ram_addr, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_sp", sp_val, 16'hffff);
    chk("rst_err", {15'b0, stack_err}, 16'h0000);
    chk("rst_oe", {15'b0, bus_oe}, 16'h0000);
    pcout = 1; #1;
    chk("rst_pc", bus_out, 16'h0000);
    pcout = 0;

    // Fetch: PC presented this cycle, capture next cycle with increment.
    tick();
    instr_enable = 1; pc_enable = 1;
    tick();
    idle_inputs(); pcout = 1; #1;
    chk("fetch_instr", instr, 16'h1234);
    chk("fetch_pc", bus_out, 16'h0001);
    chk("fetch_oe", {15'b0, bus_oe}, 16'h0001);

    // Load wins over increment.
    idle_inputs();
    pcin = 1; pc_enable = 1; bus_in = 16'h00a0;
    tick();
    idle_inputs(); pcout = 1; #1;
    chk("load_pri_bus_out", bus_out, 16'h00a0);
    chk("load_pri_oe", {15'b0, bus_oe}, 16'h0001);
    chk("load_pri_addr", ram_addr, 16'h00a0);

    // PC wrap.
    idle_inputs();
    pcin = 1; bus_in = 16'hffff;
    tick();
    idle_inputs(); #1;
    chk("pc_ffff", ram_addr, 16'hffff);
    pc_enable = 1;
    tick();
    idle_inputs(); pcout = 1; #1;
    chk("pc_wrap", bus_out, 16'h0000);
    pcout = 0; #1;
    chk("pcout_off_oe", {15'b0, bus_oe}, 16'h0000);

    // Stack: push, pop, underflow pop, reload.
    idle_inputs(); sp_sel = 2'b01; #1;
    chk("push_addr", ram_addr, 16'hfffe);
    tick();
    idle_inputs(); #1;
    chk("push_sp", sp_val, 16'hfffe);
    sp_sel = 2'b10; #1;
    chk("pop_addr", ram_addr, 16'hfffe);
    tick();
    idle_inputs(); #1;
    chk("pop_sp", sp_val, 16'hffff);
    chk("pop_err", {15'b0, stack_err}, 16'h0000);
    sp_sel = 2'b10; #1;
    chk("under_addr", ram_addr, 16'hffff);
    tick();
    idle_inputs(); #1;
    chk("under_sp", sp_val, 16'h0000);
    chk("under_err", {15'b0, stack_err}, 16'h0001);
    sp_sel = 2'b01; #1;
    chk("over_addr", ram_addr, 16'hffff);
    tick();
    idle_inputs(); #1;
    chk("over_sp", sp_val, 16'hffff);
    sp_sel = 2'b01;
    tick();
    idle_inputs(); sp_sel = 2'b11;
    tick();
    idle_inputs(); #1;
    chk("reload_sp", sp_val, 16'hffff);
    chk("reload_err_sticky", {15'b0, stack_err}, 16'h0001);

    // MAR load and address mux priority.
    addr_in = 1; bus_in = 16'h0042;
    tick();
    idle_inputs(); ram_addr_sel = 1; #1;
    chk("mar_addr", ram_addr, 16'h0042);
    sp_sel = 2'b01; #1;
    chk("sp_over_mar", ram_addr, 16'hfffe);
    sp_sel = 2'b11; #1;
    chk("reload_addr", ram_addr, 16'hffff);
    ram_addr_sel = 0; sp_sel = 2'b00; #1;
    chk("pc_sel_addr", ram_addr, 16'h0000);

    // All registers updated in one edge.
    idle_inputs();
    mem[16'h0000] = 16'hbeef;
    tick();
    pc_enable = 1; addr_in = 1; bus_in = 16'h0077; instr_enable = 1; sp_sel = 2'b01;
    tick();
    idle_inputs(); pcout = 1; #1;
    chk("indep_pc", bus_out, 16'h0001);
    chk("indep_ir", instr, 16'hbeef);
    chk("indep_sp", sp_val, 16'hfffe);
    ram_addr_sel = 1; #1;
    chk("indep_mar", ram_addr, 16'h0077);

    // Reset coinciding with load, capture and push.
    idle_inputs();
    rst = 0; pcin = 1; bus_in = 16'h1234; instr_enable = 1; sp_sel = 2'b01;
    tick();
    rst = 1; idle_inputs(); pcout = 1; #1;
    chk("mid_rst_pc", bus_out, 16'h0000);
    chk("mid_rst_ir", instr, 16'h0000);
    chk("mid_rst_sp", sp_val, 16'hffff);
    chk("mid_rst_err", {15'b0, stack_err}, 16'h0000);
    ram_addr_sel = 1; #1;
    chk("mid_rst_mar", ram_addr, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
